// File: rtl/sica_serial_out.sv
// sica_serial_out: streams estimated sources from the SICA sample RAM onto a
// valid/ready serial port in channel-major order. Reads are credit-limited so
// the small output FIFO (LATENCY+2 entries) can never overflow.
// Optional build macro: SOUT_CHANNEL_TAG_EN adds serial_s_chan, the channel
// index of each word, carried through the FIFO alongside the data.
module sica_serial_out #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SAMPLES    = 1024,
  parameter int unsigned DIM        = 5,
  parameter int unsigned LOGM       = 10,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned CH_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sout_start,
  output logic                  mem_rd_en,
  output logic [CH_WIDTH-1:0]   mem_ch_sel,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] serial_s_out,
  output logic                  serial_s_valid,
  input  logic                  serial_s_ready,
  output logic                  serial_s_last,
  output logic                  sout_busy,
  output logic                  sout_done
`ifdef SOUT_CHANNEL_TAG_EN
  ,
  output logic [CH_WIDTH-1:0]   serial_s_chan
`endif
);

  localparam int unsigned DEPTH = LATENCY + 2;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned UW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [LOGM-1:0]     smp_cnt;
  logic [CH_WIDTH-1:0] ch_cnt;
  logic [UW-1:0]       used;      // reads in flight plus FIFO occupancy
  logic                iss_last;  // last-word tag aligned with mem_rd_en

  logic                ret_v    [LATENCY];
  logic                ret_last [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic                  fifo_last [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [UW-1:0]         occ;

`ifdef SOUT_CHANNEL_TAG_EN
  logic [CH_WIDTH-1:0]   ret_chan  [LATENCY];
  logic [CH_WIDTH-1:0]   fifo_chan [DEPTH];
`endif

  logic pop;
  logic push;
  logic issue_state;
  logic can_issue;
  logic is_final;

  // Handshake, return strobe and credit check
  assign serial_s_valid = (occ != '0);
  assign serial_s_out   = fifo_data[rd_ptr];
  assign serial_s_last  = serial_s_valid & fifo_last[rd_ptr];
`ifdef SOUT_CHANNEL_TAG_EN
  assign serial_s_chan  = fifo_chan[rd_ptr];
`endif
  assign pop         = serial_s_valid & serial_s_ready;
  assign push        = ret_v[LATENCY-1];
  assign issue_state = (state == ISSUE) || ((state == IDLE) && sout_start && !sout_done);
  // A pop in this cycle frees a slot, so streaming sustains one word per cycle.
  assign can_issue   = issue_state && ((used < UW'(DEPTH)) || pop);
  assign is_final    = (ch_cnt == CH_WIDTH'(DIM - 1)) && (smp_cnt == LOGM'(SAMPLES - 1));

  // Control FSM: read issue, counters, credit tracking and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      smp_cnt     <= '0;
      ch_cnt      <= '0;
      used        <= '0;
      iss_last    <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_ch_sel  <= '0;
      mem_rd_addr <= '0;
      sout_busy   <= 1'b0;
      sout_done   <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      sout_done <= 1'b0;
      if (can_issue) begin
        mem_rd_en   <= 1'b1;
        mem_ch_sel  <= ch_cnt;
        mem_rd_addr <= ADDR_WIDTH'(smp_cnt);
        iss_last    <= is_final;
        if (is_final) begin
          smp_cnt <= '0;
          ch_cnt  <= '0;
        end else if (smp_cnt == LOGM'(SAMPLES - 1)) begin
          smp_cnt <= '0;
          ch_cnt  <= ch_cnt + CH_WIDTH'(1);
        end else begin
          smp_cnt <= smp_cnt + LOGM'(1);
        end
      end
      case ({can_issue, pop})
        2'b10:   used <= used + UW'(1);
        2'b01:   used <= used - UW'(1);
        default: used <= used;
      endcase
      case (state)
        IDLE: begin
          if (sout_start && !sout_done) begin
            state     <= is_final ? DRAIN : ISSUE;
            sout_busy <= 1'b1;
          end
        end
        ISSUE: begin
          if (can_issue && is_final) state <= DRAIN;
        end
        DRAIN: begin
          // The tagged word is the last one issued, so once it leaves the
          // FIFO is empty and nothing remains in flight.
          if (pop && fifo_last[rd_ptr]) begin
            state     <= IDLE;
            sout_busy <= 1'b0;
            sout_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return-side delay line marking which cycles carry valid read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        ret_v[i]    <= 1'b0;
        ret_last[i] <= 1'b0;
`ifdef SOUT_CHANNEL_TAG_EN
        ret_chan[i] <= '0;
`endif
      end
    end else begin
      ret_v[0]    <= mem_rd_en;
      ret_last[0] <= mem_rd_en & iss_last;
`ifdef SOUT_CHANNEL_TAG_EN
      ret_chan[0] <= mem_ch_sel;
`endif
      for (int i = 1; i < int'(LATENCY); i++) begin
        ret_v[i]    <= ret_v[i-1];
        ret_last[i] <= ret_last[i-1];
`ifdef SOUT_CHANNEL_TAG_EN
        ret_chan[i] <= ret_chan[i-1];
`endif
      end
    end
  end

  // Output FIFO: unconditional write of returned data, pop on transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
`ifdef SOUT_CHANNEL_TAG_EN
        fifo_chan[i] <= '0;
`endif
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_last[wr_ptr] <= ret_last[LATENCY-1];
`ifdef SOUT_CHANNEL_TAG_EN
        fifo_chan[wr_ptr] <= ret_chan[LATENCY-1];
`endif
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + UW'(1);
        2'b01:   occ <= occ - UW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
